// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared types and widths for the Simon sequence player
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    BLUE   = 2'b01,
    GREEN  = 2'b10,
    YELLOW = 2'b11
  } colour_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } player_state_t;

  localparam int LED_W   = 3;
  localparam int AUDIO_W = 4;

endpackage

// File: rtl/sequence_player_if.sv
// rtl/sequence_player_if.sv - CPU-side request/response bundle of the sequence player
interface sequence_player_if #(
  parameter int DEPTH = 32
);

  logic                            append;
  logic [1:0]                      push_color;
  logic                            clear;
  logic                            start;
  logic                            abort;
  logic                            led_strobe;
  logic [simon_pkg::LED_W-1:0]     led_data;
  logic                            audio_strobe;
  logic [simon_pkg::AUDIO_W-1:0]   audio_data;
  logic                            busy;
  logic                            done;
  logic [$clog2(DEPTH):0]          seq_len;
  logic                            full;

  modport master (
    output append, push_color, clear, start, abort,
    input  led_strobe, led_data, audio_strobe, audio_data, busy, done, seq_len, full
  );

  modport slave (
    input  append, push_color, clear, start, abort,
    output led_strobe, led_data, audio_strobe, audio_data, busy, done, seq_len, full
  );

endinterface

// File: rtl/seq_store.sv
// rtl/seq_store.sv - colour sequence storage with append/clear and combinational read port
module seq_store #(
  parameter int DEPTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear_en,
  input  logic                       append_en,
  input  logic [1:0]                 push_color,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [1:0]                 rd_color,
  output logic [$clog2(DEPTH):0]     seq_len,
  output logic                       full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  logic [1:0] mem [DEPTH];
  logic       do_append;

  assign full      = (seq_len == LEN_W'(DEPTH));
  assign do_append = append_en && !full;
  assign rd_color  = mem[rd_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_len <= '0;
    end else if (clear_en) begin
      seq_len <= '0;
    end else if (do_append) begin
      seq_len <= seq_len + LEN_W'(1);
    end
  end

  // Contents are don't-care after reset; seq_len alone defines what is valid.
  always_ff @(posedge clock) begin
    if (do_append) begin
      mem[seq_len[IDX_W-1:0]] <= push_color;
    end
  end

endmodule

// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - replays the stored colour sequence on the LED and tone peripherals
module sequence_player #(
  parameter int DEPTH      = 32,
  parameter int ON_CYCLES  = 25000000,
  parameter int GAP_CYCLES = 12500000,
  parameter int CNT_W      = 25
) (
  input  logic              clock,
  input  logic              reset,
  sequence_player_if.slave  bus
);
  import simon_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  player_state_t        state, state_n;
  logic [CNT_W-1:0]     timer, timer_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [1:0]           rd_color;
  logic [LEN_W-1:0]     seq_len;
  logic                 full, last, clear_en, append_en;

  logic                 strobe_q, strobe_n, on_n, busy_q, done_q, done_n;
  logic [LED_W-1:0]     led_data_q, led_data_n;
  logic [AUDIO_W-1:0]   audio_data_q, audio_data_n;

  assign clear_en  = (state == IDLE) && !bus.start && bus.clear;
  assign append_en = (state == IDLE) && !bus.start && !bus.clear && bus.append;
  assign last      = ({1'b0, idx} == seq_len - LEN_W'(1));

  // The read port follows the next index so the on strobe carries the colour being entered.
  seq_store #(.DEPTH(DEPTH)) u_store (
    .clock      (clock),
    .reset      (reset),
    .clear_en   (clear_en),
    .append_en  (append_en),
    .push_color (bus.push_color),
    .rd_idx     (idx_n),
    .rd_color   (rd_color),
    .seq_len    (seq_len),
    .full       (full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      idx          <= '0;
      strobe_q     <= 1'b0;
      led_data_q   <= '0;
      audio_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      idx          <= idx_n;
      strobe_q     <= strobe_n;
      led_data_q   <= led_data_n;
      audio_data_q <= audio_data_n;
      busy_q       <= (state_n != IDLE);
      done_q       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (bus.start && seq_len != '0) begin
          state_n = ON;
          timer_n = '0;
          idx_n   = '0;
        end
      end
      ON: begin
        if (bus.abort) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == CNT_W'(ON_CYCLES - 1)) begin
          state_n = GAP;
          timer_n = '0;
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == CNT_W'(GAP_CYCLES - 1)) begin
          timer_n = '0;
          if (last) begin
            state_n = IDLE;
          end else begin
            state_n = ON;
            idx_n   = idx + IDX_W'(1);
          end
        end else begin
          timer_n = timer + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  // Leaving ON for any reason (GAP or abort) turns the colour off; leaving GAP is silent.
  always_comb begin
    strobe_n = 1'b0;
    on_n     = 1'b0;
    if (state_n == ON && state != ON) begin
      strobe_n = 1'b1;
      on_n     = 1'b1;
    end else if (state == ON && state_n != ON) begin
      strobe_n = 1'b1;
    end
    done_n       = (state == IDLE && bus.start && seq_len == '0) ||
                   (state == GAP && state_n == IDLE && !bus.abort);
    led_data_n   = strobe_n ? {rd_color, on_n} : led_data_q;
    audio_data_n = strobe_n ? {1'b0, rd_color, on_n} : audio_data_q;
  end

  assign bus.led_strobe   = strobe_q;
  assign bus.audio_strobe = strobe_q;
  assign bus.led_data     = led_data_q;
  assign bus.audio_data   = audio_data_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.seq_len      = seq_len;
  assign bus.full         = full;

endmodule

// File: tb/tb_sequence_player.sv
// tb/tb_sequence_player.sv - scoreboard bench for sequence_player (ON=4, GAP=2, DEPTH=4)
module tb_sequence_player;
  import simon_pkg::*;

  typedef struct {
    int         cyc;
    logic       ls;
    logic       as;
    logic [2:0] ld;
    logic [3:0] ad;
    logic       b;
    logic       d;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  logic prev_busy = 1'b0;
  ev_t  q[$];

  sequence_player_if #(.DEPTH(4)) bus ();

  sequence_player #(
    .DEPTH      (4),
    .ON_CYCLES  (4),
    .GAP_CYCLES (2),
    .CNT_W      (3)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && (bus.led_strobe || bus.audio_strobe || bus.done || bus.busy != prev_busy)) begin
      ev_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d ls=%b ld=%b ad=%b busy=%b done=%b",
                 cyc, bus.led_strobe, bus.led_data, bus.audio_data, bus.busy, bus.done);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.ls != bus.led_strobe || e.as != bus.audio_strobe ||
            e.ld != bus.led_data || e.ad != bus.audio_data || e.b != bus.busy || e.d != bus.done) begin
          failures++;
          $display("FAIL event got cyc=%0d ls=%b as=%b ld=%b ad=%b busy=%b done=%b expected cyc=%0d ls=%b as=%b ld=%b ad=%b busy=%b done=%b",
                   cyc, bus.led_strobe, bus.audio_strobe, bus.led_data, bus.audio_data, bus.busy, bus.done,
                   e.cyc, e.ls, e.as, e.ld, e.ad, e.b, e.d);
        end
      end
    end
    prev_busy <= bus.busy;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic exp_ev(input int c, input logic s, input logic [2:0] ld, input logic [3:0] ad,
                        input logic b, input logic d);
    ev_t e;
    e.cyc = c; e.ls = s; e.as = s; e.ld = ld; e.ad = ad; e.b = b; e.d = d;
    q.push_back(e);
  endtask

  task automatic drive(input logic ap, input logic cl, input logic st, input logic ab, input logic [1:0] col);
    bus.append = ap; bus.clear = cl; bus.start = st; bus.abort = ab; bus.push_color = col;
    @(negedge clk);
    bus.append = 1'b0; bus.clear = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // red, green, yellow played from a start sampled at edge t
  task automatic exp_play3(input int t);
    exp_ev(t + 1,  1'b1, 3'b001, 4'b0001, 1'b1, 1'b0);
    exp_ev(t + 5,  1'b1, 3'b000, 4'b0000, 1'b1, 1'b0);
    exp_ev(t + 7,  1'b1, 3'b101, 4'b0101, 1'b1, 1'b0);
    exp_ev(t + 11, 1'b1, 3'b100, 4'b0100, 1'b1, 1'b0);
    exp_ev(t + 13, 1'b1, 3'b111, 4'b0111, 1'b1, 1'b0);
    exp_ev(t + 17, 1'b1, 3'b110, 4'b0110, 1'b1, 1'b0);
    exp_ev(t + 19, 1'b0, 3'b110, 4'b0110, 1'b0, 1'b1);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    bus.append = 1'b0; bus.clear = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.push_color = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_led_strobe", int'(bus.led_strobe), 0);
    chk("reset_audio_strobe", int'(bus.audio_strobe), 0);
    chk("reset_led_data", int'(bus.led_data), 0);
    chk("reset_audio_data", int'(bus.audio_data), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_seq_len", int'(bus.seq_len), 0);
    chk("reset_full", int'(bus.full), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    drive(1'b1, 1'b0, 1'b0, 1'b0, RED);
    drive(1'b1, 1'b0, 1'b0, 1'b0, GREEN);
    drive(1'b1, 1'b0, 1'b0, 1'b0, YELLOW);
    chk("basic_seq_len", int'(bus.seq_len), 3);
    t = cyc;
    exp_play3(t);
    drive(1'b0, 1'b0, 1'b1, 1'b0, RED);
    wait_until(t + 22);
    chk("basic_queue_empty", q.size(), 0);

    t = cyc;
    exp_play3(t);
    drive(1'b0, 1'b0, 1'b1, 1'b0, RED);
    wait_until(t + 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, BLUE);
    wait_until(t + 8);
    drive(1'b0, 1'b1, 1'b0, 1'b0, RED);
    wait_until(t + 14);
    drive(1'b0, 1'b0, 1'b1, 1'b0, RED);
    wait_until(t + 22);
    chk("busy_writes_seq_len", int'(bus.seq_len), 3);
    chk("busy_writes_queue_empty", q.size(), 0);

    t = cyc;
    exp_ev(t + 1, 1'b1, 3'b001, 4'b0001, 1'b1, 1'b0);
    exp_ev(t + 4, 1'b1, 3'b000, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, RED);
    wait_until(t + 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, RED);
    wait_until(t + 10);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_queue_empty", q.size(), 0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, RED);
    chk("clear_seq_len", int'(bus.seq_len), 0);
    t = cyc;
    exp_ev(t + 1, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, RED);
    wait_until(t + 5);
    chk("empty_start_queue_empty", q.size(), 0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, BLUE);
    drive(1'b1, 1'b0, 1'b0, 1'b0, GREEN);
    drive(1'b1, 1'b0, 1'b0, 1'b0, YELLOW);
    drive(1'b1, 1'b0, 1'b0, 1'b0, RED);
    chk("overflow_full_at_4", int'(bus.full), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, GREEN);
    chk("overflow_seq_len", int'(bus.seq_len), 4);
    chk("overflow_full", int'(bus.full), 1);
    t = cyc;
    exp_ev(t + 1,  1'b1, 3'b011, 4'b0011, 1'b1, 1'b0);
    exp_ev(t + 5,  1'b1, 3'b010, 4'b0010, 1'b1, 1'b0);
    exp_ev(t + 7,  1'b1, 3'b101, 4'b0101, 1'b1, 1'b0);
    exp_ev(t + 11, 1'b1, 3'b100, 4'b0100, 1'b1, 1'b0);
    exp_ev(t + 13, 1'b1, 3'b111, 4'b0111, 1'b1, 1'b0);
    exp_ev(t + 17, 1'b1, 3'b110, 4'b0110, 1'b1, 1'b0);
    exp_ev(t + 19, 1'b1, 3'b001, 4'b0001, 1'b1, 1'b0);
    exp_ev(t + 23, 1'b1, 3'b000, 4'b0000, 1'b1, 1'b0);
    exp_ev(t + 25, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, RED);
    wait_until(t + 28);
    chk("overflow_queue_empty", q.size(), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, RED);
    chk("overflow_clear_seq_len", int'(bus.seq_len), 0);
    chk("overflow_clear_full", int'(bus.full), 0);

    t = cyc;
    exp_ev(t + 1, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, GREEN);
    wait_until(t + 4);
    chk("collide_empty_seq_len", int'(bus.seq_len), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, RED);
    t = cyc;
    exp_ev(t + 1, 1'b1, 3'b001, 4'b0001, 1'b1, 1'b0);
    exp_ev(t + 5, 1'b1, 3'b000, 4'b0000, 1'b1, 1'b0);
    exp_ev(t + 7, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, GREEN);
    wait_until(t + 10);
    chk("collide_seq_len", int'(bus.seq_len), 1);
    chk("collide_queue_empty", q.size(), 0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, RED);
    drive(1'b1, 1'b0, 1'b0, 1'b0, YELLOW);
    t = cyc;
    exp_ev(t + 1, 1'b1, 3'b111, 4'b0111, 1'b1, 1'b0);
    exp_ev(t + 5, 1'b1, 3'b110, 4'b0110, 1'b1, 1'b0);
    exp_ev(t + 6, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, RED);
    wait_until(t + 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midgap_reset_led_data", int'(bus.led_data), 0);
    chk("midgap_reset_audio_data", int'(bus.audio_data), 0);
    chk("midgap_reset_busy", int'(bus.busy), 0);
    chk("midgap_reset_strobe", int'(bus.led_strobe), 0);
    chk("midgap_reset_seq_len", int'(bus.seq_len), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
- Hardware sequencer for the Simon-style game. It stores the colour sequence built up by the CPU and replays it autonomously on the LED (`light_up`) and tone (`audio`) peripherals.
- Replaces software delay loops: the CPU appends colours, issues start, then polls busy/done.
- Sits beside the memory-mapped I/O decode in the top level; its strobe/data outputs are muxed with the CPU's direct LED/audio writes, with the player winning while busy.

Parameters:
- DEPTH, 32: maximum sequence length; must be a power of 2.
- ON_CYCLES, 25000000: cycles each colour is lit and sounding (0.5 s at 50 MHz).
- GAP_CYCLES, 12500000: dark/silent cycles after each colour.
- CNT_W, 25: timer width; must satisfy 2^CNT_W > max(ON_CYCLES, GAP_CYCLES).

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- append  in  1  one-cycle request to add push_color at index seq_len
- push_color  in  2  colour code: 00 red, 01 blue, 10 green, 11 yellow
- clear  in  1  one-cycle request to set seq_len to 0
- start  in  1  one-cycle request to replay indices 0..seq_len-1
- abort  in  1  one-cycle request to stop playback
- led_strobe  out  1  one-cycle write pulse to `light_up`
- led_data  out  3  {colour[1:0], on_off}
- audio_strobe  out  1  one-cycle write pulse to `audio`
- audio_data  out  4  {1'b0, colour[1:0], on_off}
- busy  out  1  high while playback is in progress
- done  out  1  one-cycle pulse when playback completes normally
- seq_len  out  $clog2(DEPTH)+1  number of stored colours
- full  out  1  seq_len == DEPTH

Behaviour:
- Reset
  - All outputs 0, seq_len 0, state IDLE, timer 0.
  - Stored colour data is don't-care after reset.
  - Reset mid-playback issues no off strobe; the peripherals are reset by the same system reset.
- All outputs are registered.
- States: IDLE, ON, GAP.
- IDLE
  - clear: seq_len <= 0.
  - append && !full: mem[seq_len] <= push_color, seq_len += 1.
  - start && seq_len != 0: go to ON, idx <= 0.
  - start && seq_len == 0: done pulses in the next cycle; state stays IDLE.
- Priority in IDLE when requests coincide: start > clear > append. The losing requests are dropped.
- append while full: ignored, seq_len unchanged.
- append or clear while busy: ignored.
- start while busy: ignored.
- Entering ON
  - In the first ON cycle: led_strobe = audio_strobe = 1, on_off = 1, colour = mem[idx].
  - ON lasts exactly ON_CYCLES cycles.
- Entering GAP
  - In the first GAP cycle: both strobes = 1, on_off = 0, same colour.
  - GAP lasts exactly GAP_CYCLES cycles.
- End of GAP
  - If idx == seq_len-1: go to IDLE; done = 1 in the first IDLE cycle.
  - Otherwise: idx += 1 and go to ON.
- busy = (state != IDLE).
  - Start sampled at edge T gives busy from cycle T+1 through the last GAP cycle.
- Latency: start to first on strobe is 1 cycle.
- Per-colour period is ON_CYCLES + GAP_CYCLES.
- abort (any non-IDLE state): next state IDLE, no done pulse.
  - If aborted in ON, an off strobe for the current colour is issued in the first IDLE cycle.
  - If aborted in GAP, no strobe is issued.
  - abort takes priority over the timer-expiry transition in the same cycle.
- Strobes are never high on two consecutive cycles.
- led_data and audio_data hold their last value when the strobe is low.
- seq_len saturates at DEPTH; idx never exceeds seq_len-1.

Decomposition:
- Shared package `simon_pkg`:
  - colour codes RED/BLUE/GREEN/YELLOW (2-bit)
  - player state enum {IDLE, ON, GAP}
  - LED and audio data widths (3, 4)
- Sub-module `seq_store`:
  - DEPTH x 2 register array with write pointer = seq_len, plus clear and append logic
  - asynchronous read port indexed by idx
  - outputs seq_len and full
- The timer and FSM stay in the top of `sequence_player`.

Test Plan (ON_CYCLES=4, GAP_CYCLES=2, DEPTH=4):
- Basic playback:
  - Stimulus: append red, green, yellow; start at edge T.
  - Required: on strobes in T+1, T+7, T+13 with led_data 001, 101, 111; off strobes in T+5, T+11, T+17; busy high T+1..T+18; done in T+19 only.
- Empty start:
  - Stimulus: start with seq_len 0.
  - Required: done one cycle later, busy never high, no strobes.
- Overflow:
  - Stimulus: append 5 times.
  - Required: seq_len 4, full 1; the 5th colour is not stored.
  - Follow-up: clear gives seq_len 0 and full 0.
- Abort in ON:
  - Stimulus: abort at T+3 during playback.
  - Required: IDLE at T+4, off strobe (colour red, on_off 0) at T+4, no done, busy 0.
- Writes while busy:
  - Stimulus: append, clear and start during playback.
  - Required: seq_len and playback order unchanged.
- Collisions and reset:
  - start and append in the same IDLE cycle: the append is dropped.
  - Reset mid-GAP: all outputs 0 next cycle, seq_len 0.
